// File: rtl/instr_mem_loader.sv
// Write side of the instruction memory: packs a big-endian byte stream into
// 32-bit words, stalls the pipeline while loading, then pulses pipe_rst and releases it.
module instr_mem_loader #(
  parameter int          ADDR_WIDTH = 9,
  parameter logic [31:0] TERM_WORD  = 32'hFFFF_FFFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_din,
  output logic                  pipe_en,
  output logic                  pipe_rst,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH:0]   word_count,
  output logic [2:0]            state_dbg
);

  // Handshake: a byte is consumed on every rising edge where rx_valid is high,
  // the loader is in LOAD and start is low; there is no back-pressure.

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    RELEASE = 3'd2,
    RUN     = 3'd3,
    ERROR   = 3'd4
  } state_t;

  state_t      state;
  state_t      stateNext;
  logic [1:0]  byteCnt;
  logic [23:0] asmReg;
  logic [31:0] wordNext;
  logic        wordDone;
  logic        memFull;
  logic        doWrite;

  assign state_dbg = state;

  always_comb begin
    wordNext  = {asmReg, rx_data};
    memFull   = word_count[ADDR_WIDTH];
    wordDone  = (state == LOAD) && !start && rx_valid && (byteCnt == 2'd3);
    doWrite   = wordDone && (wordNext != TERM_WORD) && !memFull;
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = LOAD;
      LOAD: begin
        if (start) begin
          stateNext = LOAD;
        end else if (wordDone) begin
          // Terminator is checked first so a full memory still releases cleanly.
          if (wordNext == TERM_WORD) stateNext = RELEASE;
          else if (memFull)          stateNext = ERROR;
        end
      end
      RELEASE: stateNext = RUN;
      RUN:     if (start) stateNext = LOAD;
      ERROR:   if (start) stateNext = LOAD;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byteCnt    <= 2'd0;
      asmReg     <= 24'd0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= 32'd0;
      pipe_en    <= 1'b0;
      pipe_rst   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      word_count <= '0;
    end else begin
      state    <= stateNext;
      mem_we   <= doWrite;
      // Status outputs are decoded from the next state so they line up with state.
      busy     <= (stateNext == LOAD);
      done     <= (stateNext == RUN);
      error    <= (stateNext == ERROR);
      pipe_en  <= (stateNext == RUN);
      pipe_rst <= (stateNext == RELEASE);
      if (start && (stateNext == LOAD)) begin
        byteCnt    <= 2'd0;
        asmReg     <= 24'd0;
        word_count <= '0;
      end else if ((state == LOAD) && rx_valid) begin
        byteCnt <= byteCnt + 2'd1;
        asmReg  <= wordNext[23:0];
        if (doWrite) begin
          mem_addr   <= word_count[ADDR_WIDTH-1:0];
          mem_din    <= wordNext;
          word_count <= word_count + (ADDR_WIDTH+1)'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Directed bench for instr_mem_loader built with a 4-word memory so overflow is reachable.
module tb_instr_mem_loader;

  localparam int AW = 2;

  logic          clk;
  logic          rst;
  logic          start;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_din;
  logic          pipe_en;
  logic          pipe_rst;
  logic          busy;
  logic          done;
  logic          error;
  logic [AW:0]   word_count;
  logic [2:0]    state_dbg;

  int total = 0;
  int bad   = 0;
  logic [AW+31:0] exp_q[$];

  instr_mem_loader #(.ADDR_WIDTH(AW), .TERM_WORD(32'hFFFF_FFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .pipe_en(pipe_en),
    .pipe_rst(pipe_rst), .busy(busy), .done(done), .error(error),
    .word_count(word_count), .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every write pulse must match the head of exp_q
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_write observed=%0h@%0h expected=no_write", mem_din, mem_addr);
      end else begin
        chk("write", {mem_addr, mem_din}, exp_q.pop_front());
      end
    end
  end

  // drivers
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8]);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_state"}, state_dbg, 3'd0);
    chk({tag, "_we"}, mem_we, 1'b0);
    chk({tag, "_addr"}, mem_addr, 2'd0);
    chk({tag, "_din"}, mem_din, 32'd0);
    chk({tag, "_pipe_en"}, pipe_en, 1'b0);
    chk({tag, "_pipe_rst"}, pipe_rst, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
    chk({tag, "_wcount"}, word_count, 3'd0);
  endtask

  logic [7:0] t2_bytes [12];

  initial begin
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    tick(); tick();
    check_reset("reset");
    rst = 1'b0;
    tick();
    chk("idle_hold", state_dbg, 3'd0);

    // back-to-back stream
    exp_q.push_back({2'd0, 32'h2008_0005});
    exp_q.push_back({2'd1, 32'h0000_0000});
    pulse_start();
    chk("t1_busy", busy, 1'b1);
    chk("t1_state_load", state_dbg, 3'd1);
    send_word(32'h2008_0005);
    chk("t1_we0", mem_we, 1'b1);
    chk("t1_addr0", mem_addr, 2'd0);
    chk("t1_wc1", word_count, 3'd1);
    send_word(32'h0000_0000);
    chk("t1_we1", mem_we, 1'b1);
    chk("t1_addr1", mem_addr, 2'd1);
    chk("t1_wc2", word_count, 3'd2);
    send_word(32'hFFFF_FFFF);
    chk("t1_state_rel", state_dbg, 3'd2);
    chk("t1_pipe_rst", pipe_rst, 1'b1);
    chk("t1_pipe_en_low", pipe_en, 1'b0);
    chk("t1_no_we_term", mem_we, 1'b0);
    chk("t1_busy_low", busy, 1'b0);
    tick();
    chk("t1_pipe_rst_low", pipe_rst, 1'b0);
    chk("t1_pipe_en", pipe_en, 1'b1);
    chk("t1_done", done, 1'b1);
    chk("t1_wc_final", word_count, 3'd2);
    chk("t1_drained", exp_q.size(), 0);

    // spaced bytes; restart from RUN
    t2_bytes = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00,
                 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_q.push_back({2'd0, 32'h2008_0005});
    exp_q.push_back({2'd1, 32'h0000_0000});
    pulse_start();
    chk("t2_pipe_en_drop", pipe_en, 1'b0);
    chk("t2_done_drop", done, 1'b0);
    chk("t2_wc_clear", word_count, 3'd0);
    for (int i = 0; i < 12; i++) begin
      send_byte(t2_bytes[i]);
      tick();
      tick();
    end
    chk("t2_state_run", state_dbg, 3'd3);
    chk("t2_done", done, 1'b1);
    chk("t2_wc", word_count, 3'd2);
    chk("t2_drained", exp_q.size(), 0);

    // bytes in RUN are ignored; start wins over a coincident byte
    send_word(32'h1122_3344);
    send_word(32'h5566_7788);
    chk("t3_run_ignore_wc", word_count, 3'd2);
    chk("t3_run_ignore_state", state_dbg, 3'd3);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'hAB;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    chk("t3_load", state_dbg, 3'd1);
    send_byte(8'hAA); send_byte(8'hBB); send_byte(8'hCC);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    tick();
    start = 1'b0; rx_valid = 1'b0;
    exp_q.push_back({2'd0, 32'h1234_5678});
    send_word(32'h1234_5678);
    chk("t3_din", mem_din, 32'h1234_5678);
    chk("t3_addr", mem_addr, 2'd0);
    chk("t3_wc", word_count, 3'd1);
    send_word(32'hFFFF_FFFF);
    tick();
    chk("t3_run", state_dbg, 3'd3);
    chk("t3_drained", exp_q.size(), 0);

    // overflow with a 4-word memory
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'(i), 32'hA000_0000 | 32'(i)});
      send_word(32'hA000_0000 | 32'(i));
    end
    chk("t4_full_wc", word_count, 3'd4);
    send_word(32'hDEAD_BEEF);
    chk("t4_state_err", state_dbg, 3'd4);
    chk("t4_error", error, 1'b1);
    chk("t4_no_we", mem_we, 1'b0);
    chk("t4_pipe_en", pipe_en, 1'b0);
    chk("t4_wc_hold", word_count, 3'd4);
    send_word(32'h0102_0304);
    chk("t4_err_ignore", error, 1'b1);
    pulse_start();
    chk("t4_restart_busy", busy, 1'b1);
    chk("t4_restart_err_low", error, 1'b0);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back({2'(i), 32'hB000_0000 | 32'(i)});
      send_word(32'hB000_0000 | 32'(i));
    end
    send_word(32'hFFFF_FFFF);
    chk("t4_full_term_rel", state_dbg, 3'd2);
    tick();
    chk("t4_run_done", done, 1'b1);
    chk("t4_run_pipe_en", pipe_en, 1'b1);
    chk("t4_run_wc", word_count, 3'd4);
    chk("t4_drained", exp_q.size(), 0);

    // rst coincident with the 4th byte
    pulse_start();
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
    rx_valid = 1'b1; rx_data = 8'h04; rst = 1'b1;
    tick();
    rx_valid = 1'b0;
    check_reset("t5_rst");
    rst = 1'b0;
    tick();
    chk("t5_idle", state_dbg, 3'd0);
    chk("t5_no_we", mem_we, 1'b0);
    chk("t5_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_mem_loader.md
# instr_mem_loader

Program loader for the pipelined MIPS core: the write side of the instruction memory that the fetch stage reads. It receives a byte stream (from the UART receiver), packs bytes into 32-bit instruction words and writes them to consecutive instruction-memory word addresses. It holds the pipeline stalled while loading, then pulses a pipeline reset and releases it. A terminator word ends the load.

## Interface
Parameters:
- ADDR_WIDTH, 9, instruction-memory word-address width; must match the PC width.
- TERM_WORD, 32'hFFFF_FFFF, end-of-program marker; it is never written to memory.

Ports:
- clk  in  1  single clock; everything in the block is rising-edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse that begins a new load.
- rx_data  in  8  received byte.
- rx_valid  in  1  rx_data is valid this cycle; one byte per asserted cycle.
- mem_we  out  1  instruction-memory write enable.
- mem_addr  out  ADDR_WIDTH  instruction-memory word address.
- mem_din  out  32  instruction word to write.
- pipe_en  out  1  pipeline enable, driving the IF/ID latch and PC enables; 0 stalls the core.
- pipe_rst  out  1  one-cycle pulse that clears the pipeline before release.
- busy  out  1  high while in LOAD.
- done  out  1  high while in RUN.
- error  out  1  high while in ERROR (overflow).
- word_count  out  ADDR_WIDTH+1  number of words written by the current or last load.

## Operation
States: IDLE, LOAD, RELEASE, RUN, ERROR.

- **IDLE** (reset state)
  - Outputs: pipe_en=0, no writes.
  - Transition: start -> LOAD.
- **LOAD**
  - On entry, clear byte_cnt and word_count.
  - Each cycle with rx_valid, shift rx_data into the assembly register. The first byte is bits [31:24] (big-endian, MSB first). byte_cnt wraps 0..3.
  - On the 4th byte, act on the completed word:
    - word == TERM_WORD -> RELEASE, no write.
    - word_count == 2^ADDR_WIDTH -> ERROR, no write.
    - otherwise -> write it at address word_count, then word_count+1.
- **RELEASE**
  - One cycle with pipe_rst=1 and pipe_en=0, then -> RUN.
- **RUN**
  - pipe_en=1, done=1.
  - Transition: start -> LOAD, and pipe_en drops in the same cycle the state changes.
- **ERROR**
  - pipe_en=0, error=1.
  - Transition: start -> LOAD.
- start while in LOAD restarts the load: partial word discarded, byte_cnt=0, word_count=0.
- rx_valid is ignored outside LOAD.
- A partial word (1-3 bytes) never causes a write.

## Timing
- Reset values: state=IDLE, mem_we=0, mem_addr=0, mem_din=0, pipe_en=0, pipe_rst=0, busy=0, done=0, error=0, word_count=0, byte_cnt=0.
- All outputs are registered.
- Writes:
  - mem_we is high for exactly one cycle, in the cycle after the edge that sampled the 4th byte.
  - mem_addr and mem_din are valid in that same cycle.
  - word_count increments on the same edge that asserts mem_we.
- Throughput: rx_valid may be high on every cycle; back-to-back words are written on consecutive cycles with no byte lost.
- Terminator: the edge sampling the 4th terminator byte enters RELEASE. pipe_rst is high for the next cycle, and pipe_en and done rise one cycle after that.
- start in the same cycle as an rx_valid:
  - In LOAD, start wins and the byte is dropped.
  - In IDLE, RUN or ERROR, the byte is ignored.
- Overflow: with word_count==2^ADDR_WIDTH, the next complete non-terminator word sets error on the following cycle. A terminator at that point still releases normally.
- rst mid-load: returns to IDLE on the next edge. mem_we is forced 0 in the cycle after rst is sampled, even if a 4th byte arrived in that same cycle.
- Memory contents are not cleared by rst or start.

## Test plan
- Reset, start, then bytes 20 08 00 05 00 00 00 00 FF FF FF FF with rx_valid every cycle. Required: writes 0x20080005@0 and 0x00000000@1 on consecutive cycles; word_count=2; pipe_rst pulses once; pipe_en=1 and done=1 afterwards.
- Bytes spaced by idle cycles: same writes, one mem_we pulse per word, no extra writes.
- Send 3 bytes, pulse start, then the full stream. Required: the first write is at address 0 with the correct word, not a partial assembly.
- ADDR_WIDTH=2: 4 words fill memory, a 5th non-terminator word gives error=1 with no write and pipe_en=0; a following start plus terminator reaches RUN.
- Assert rst coincident with the 4th byte of a word. Required: no mem_we, every output at its reset value, state IDLE.
- In RUN, pulse start. Required: pipe_en=0 on the next cycle and bytes resume being accepted; bytes sent while in RUN are ignored.
